pipelined_cpu_core: RTL and testbench

//  Parametrised 4-stage pipelined successor to the single-cycle 16-bit datapath (IF, ID, EX/MEM, WB).

---
 rtl/pipelined_cpu_core_if.sv | 27 ++
 rtl/pipelined_cpu_core.sv | 196 +++++++++++++++++++
 tb/tb_pipelined_cpu_core.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cpu_core_if.sv
// Memory-side bus of the pipelined core: combinational instruction fetch port
// plus a data port gated by a single ready signal.
interface pipelined_cpu_core_if #(
   parameter int DSIZE = 16,
   parameter int ISIZE = 16
);
   logic [ISIZE-1:0] imem_addr;
   logic [15:0]      imem_rdata;
   logic [DSIZE-1:0] dmem_addr;
   logic [DSIZE-1:0] dmem_wdata;
   logic             dmem_wen;
   logic             dmem_ren;
   logic [DSIZE-1:0] dmem_rdata;
   logic             dmem_ready;

   // Handshake: dmem_wen/dmem_ren act as the request valid and stay stable with
   // addr/wdata until a cycle with dmem_ready=1, where a store commits and load
   // data on dmem_rdata is taken; dmem_ready=0 freezes the requester.
   modport master (
      output imem_addr, dmem_addr, dmem_wdata, dmem_wen, dmem_ren,
      input  imem_rdata, dmem_rdata, dmem_ready
   );
   modport slave (
      input  imem_addr, dmem_addr, dmem_wdata, dmem_wen, dmem_ren,
      output imem_rdata, dmem_rdata, dmem_ready
   );
endinterface

// File: rtl/pipelined_cpu_core.sv
// 4-stage (IF, ID, EX/MEM, WB) 16-bit-ISA core with WB->EX forwarding or
// interlock, branch flush in EX and a global freeze on data-memory not-ready.
module pipelined_cpu_core #(
   parameter int          DSIZE    = 16,
   parameter int          ISIZE    = 16,
   parameter int          NREG     = 16,
   parameter bit          FWD_EN   = 1'b1,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   pipelined_cpu_core_if.master  mem,
   output logic                  stall,
   output logic                  flush,
   output logic                  retire_valid,
   output logic [3:0]            retire_waddr,
   output logic [DSIZE-1:0]      retire_wdata,
   output logic [15:0]           stall_count
);
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_ADDI = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_SW   = 4'd6;
   localparam logic [3:0] OP_BEQ  = 4'd7;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_fn;
   } ctl_t;

   logic [DSIZE-1:0] regs [NREG];
   logic [ISIZE-1:0] pc;

   logic             id_valid;
   logic [15:0]      id_inst;
   logic [ISIZE-1:0] id_pc;
   ctl_t             id_ctl;
   logic             id_reg_dst, id_uses_a, id_uses_b;
   logic [3:0]       id_raddr1, id_raddr2;
   logic [DSIZE-1:0] id_rdata1, id_rdata2;

   logic             ex_valid;
   ctl_t             ex_ctl;
   logic [ISIZE-1:0] ex_pc;
   logic [3:0]       ex_raddr1, ex_raddr2, ex_waddr, ex_imm;
   logic [DSIZE-1:0] ex_rdata1, ex_rdata2;
   logic [DSIZE-1:0] op_a, op_b, alu_b, alu_out;
   logic [ISIZE-1:0] target;
   logic             taken, hazard, stall_i;

   logic             wb_valid, wb_wen, wb_write;
   logic [3:0]       wb_waddr;
   logic [DSIZE-1:0] wb_wdata;

   function automatic logic reg_exists(input logic [3:0] a);
      return (NREG >= 16) || (int'(a) < NREG);
   endfunction

   always_comb begin
      id_ctl     = '0;
      id_reg_dst = 1'b0;
      id_uses_a  = 1'b0;
      id_uses_b  = 1'b0;
      case (id_inst[15:12])
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            id_ctl.reg_write = 1'b1;
            id_ctl.alu_fn    = id_inst[13:12];
            id_uses_a        = 1'b1;
            id_uses_b        = 1'b1;
         end
         OP_ADDI: begin
            id_ctl.reg_write = 1'b1;
            id_ctl.alu_src   = 1'b1;
            id_uses_a        = 1'b1;
         end
         OP_LW: begin
            id_ctl.reg_write  = 1'b1;
            id_ctl.mem_to_reg = 1'b1;
            id_ctl.alu_src    = 1'b1;
            id_uses_a         = 1'b1;
         end
         OP_SW: begin
            id_ctl.mem_write = 1'b1;
            id_ctl.alu_src   = 1'b1;
            id_reg_dst       = 1'b1;
            id_uses_a        = 1'b1;
            id_uses_b        = 1'b1;
         end
         OP_BEQ: begin
            id_ctl.branch = 1'b1;
            id_ctl.alu_fn = 2'd1;
            id_reg_dst    = 1'b1;
            id_uses_a     = 1'b1;
            id_uses_b     = 1'b1;
         end
         default: ;
      endcase
   end

   assign id_raddr1 = id_inst[7:4];
   assign id_raddr2 = id_reg_dst ? id_inst[11:8] : id_inst[3:0];
   assign wb_write  = wb_valid & wb_wen;

   // Register read with write-through of the pending WB result.
   always_comb begin
      id_rdata1 = '0;
      id_rdata2 = '0;
      if (reg_exists(id_raddr1)) id_rdata1 = regs[id_raddr1];
      if (reg_exists(id_raddr2)) id_rdata2 = regs[id_raddr2];
      if (wb_write && wb_waddr == id_raddr1) id_rdata1 = wb_wdata;
      if (wb_write && wb_waddr == id_raddr2) id_rdata2 = wb_wdata;
   end

   always_comb begin
      op_a = ex_rdata1;
      op_b = ex_rdata2;
      if (FWD_EN && wb_write && wb_waddr == ex_raddr1) op_a = wb_wdata;
      if (FWD_EN && wb_write && wb_waddr == ex_raddr2) op_b = wb_wdata;
      alu_b = ex_ctl.alu_src ? {{(DSIZE-4){ex_imm[3]}}, ex_imm} : op_b;
      case (ex_ctl.alu_fn)
         2'd0:    alu_out = op_a + alu_b;
         2'd1:    alu_out = op_a - alu_b;
         2'd2:    alu_out = op_a & alu_b;
         default: alu_out = op_a | alu_b;
      endcase
   end

   assign taken  = ex_valid & ex_ctl.branch & (alu_out == '0);
   assign target = ex_pc + ISIZE'(1) + {{(ISIZE-4){ex_imm[3]}}, ex_imm};

   // Only the EX producer can be missed without forwarding; WB is covered by write-through.
   assign hazard = !FWD_EN && id_valid && ex_valid && ex_ctl.reg_write &&
                   ((id_uses_a && ex_waddr == id_raddr1) ||
                    (id_uses_b && ex_waddr == id_raddr2));
   assign stall_i = !mem.dmem_ready || (hazard && !taken);

   assign mem.imem_addr  = pc;
   assign mem.dmem_addr  = alu_out;
   assign mem.dmem_wdata = op_b;
   assign mem.dmem_wen   = rst & ex_valid & ex_ctl.mem_write;
   assign mem.dmem_ren   = rst & ex_valid & ex_ctl.mem_to_reg;

   assign stall        = rst & stall_i;
   assign flush        = rst & mem.dmem_ready & taken;
   assign retire_valid = rst & mem.dmem_ready & wb_write;
   assign retire_waddr = wb_waddr;
   assign retire_wdata = wb_wdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc          <= ISIZE'(RESET_PC);
         id_valid    <= 1'b0;
         ex_valid    <= 1'b0;
         wb_valid    <= 1'b0;
         stall_count <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (stall_i && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
         if (mem.dmem_ready) begin
            if (wb_write && reg_exists(wb_waddr)) regs[wb_waddr] <= wb_wdata;
            wb_valid <= ex_valid;
            wb_wen   <= ex_ctl.reg_write;
            wb_waddr <= ex_waddr;
            wb_wdata <= ex_ctl.mem_to_reg ? mem.dmem_rdata : alu_out;
            if (taken) begin
               pc       <= target;
               id_valid <= 1'b0;
               ex_valid <= 1'b0;
            end else if (hazard) begin
               ex_valid <= 1'b0;
            end else begin
               pc        <= pc + ISIZE'(1);
               id_valid  <= 1'b1;
               id_inst   <= mem.imem_rdata;
               id_pc     <= pc;
               ex_valid  <= id_valid;
               ex_ctl    <= id_ctl;
               ex_pc     <= id_pc;
               ex_raddr1 <= id_raddr1;
               ex_raddr2 <= id_raddr2;
               ex_waddr  <= id_inst[11:8];
               ex_imm    <= id_inst[3:0];
               ex_rdata1 <= id_rdata1;
               ex_rdata2 <= id_rdata2;
            end
         end
      end
   end
endmodule

// File: tb/tb_pipelined_cpu_core.sv
// Directed bench: one forwarding core (a) and one interlocking core (b) share
// instruction memory, load data, clock, reset and dmem_ready.
module tb_pipelined_cpu_core;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ready = 1'b1;
   always #5 clk = ~clk;

   localparam logic [15:0] NOP = 16'hF000;

   logic [15:0] imem [16];
   logic [15:0] dmem [16];
   logic [19:0] exp_q [$];
   int errors = 0;
   int checks = 0;

   int          wr_a = 0, wr_b = 0;
   logic [15:0] wa_addr, wa_data;

   pipelined_cpu_core_if #(.DSIZE(16), .ISIZE(16)) bus_a ();
   pipelined_cpu_core_if #(.DSIZE(16), .ISIZE(16)) bus_b ();

   logic        stall_a, flush_a, rv_a, stall_b, flush_b, rv_b;
   logic [3:0]  rwa_a, rwa_b;
   logic [15:0] rwd_a, rwd_b, sc_a, sc_b;

   assign bus_a.imem_rdata = imem[bus_a.imem_addr[3:0]];
   assign bus_a.dmem_rdata = dmem[bus_a.dmem_addr[3:0]];
   assign bus_a.dmem_ready = ready;
   assign bus_b.imem_rdata = imem[bus_b.imem_addr[3:0]];
   assign bus_b.dmem_rdata = dmem[bus_b.dmem_addr[3:0]];
   assign bus_b.dmem_ready = ready;

   pipelined_cpu_core #(.FWD_EN(1'b1)) dut_a (
      .clk(clk), .rst(rst), .mem(bus_a), .stall(stall_a), .flush(flush_a),
      .retire_valid(rv_a), .retire_waddr(rwa_a), .retire_wdata(rwd_a), .stall_count(sc_a)
   );
   pipelined_cpu_core #(.FWD_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst), .mem(bus_b), .stall(stall_b), .flush(flush_b),
      .retire_valid(rv_b), .retire_waddr(rwa_b), .retire_wdata(rwd_b), .stall_count(sc_b)
   );

   always @(posedge clk) begin
      if (bus_a.dmem_wen && bus_a.dmem_ready) begin
         wr_a    <= wr_a + 1;
         wa_addr <= bus_a.dmem_addr;
         wa_data <= bus_a.dmem_wdata;
      end
      if (bus_b.dmem_wen && bus_b.dmem_ready) wr_b <= wr_b + 1;
   end

   function automatic logic [15:0] enc(input logic [3:0] op, rd, rs, rt);
      return {op, rd, rs, rt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_nops();
      for (int i = 0; i < 16; i++) begin
         imem[i] = NOP;
         dmem[i] = 16'h0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ready = 1'b1;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      load_nops();
      rst = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus_a.imem_addr !== 16'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", bus_a.imem_addr); end
      checks++;
      if (bus_a.dmem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b want 0", bus_a.dmem_wen); end
      checks++;
      if (rv_a !== 1'b0) begin errors++; $display("FAIL reset_retire: got %0b want 0", rv_a); end
      checks++;
      if (sc_a !== 16'd0) begin errors++; $display("FAIL reset_stall_count: got %0d want 0", sc_a); end
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus_a.imem_addr !== 16'(i)) begin
            errors++; $display("FAIL fetch_seq[%0d]: got %0h want %0h", i, bus_a.imem_addr, i);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      int n_stall_a = 0, n_stall_b = 0;
      load_nops();
      imem[0] = enc(4'd5, 4'd1, 4'd0, 4'd0);   // LW r1,0(r0)
      imem[1] = enc(4'd0, 4'd2, 4'd1, 4'd1);   // ADD r2,r1,r1
      dmem[0] = 16'd5;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (stall_a) n_stall_a++;
         if (stall_b) n_stall_b++;
         if (c == 2) begin
            checks++;
            if ({bus_a.dmem_ren, bus_a.dmem_addr} !== {1'b1, 16'd0}) begin
               errors++; $display("FAIL lw_request: ren=%0b addr=%0h want ren=1 addr=0", bus_a.dmem_ren, bus_a.dmem_addr);
            end
         end
         if (c == 3) begin
            checks++;
            if ({rv_a, rwa_a, rwd_a} !== {1'b1, 4'd1, 16'd5}) begin
               errors++; $display("FAIL fwd_lw_retire: v=%0b r%0d=%0d want v=1 r1=5", rv_a, rwa_a, rwd_a);
            end
         end
         if (c == 4) begin
            checks++;
            if ({rv_a, rwa_a, rwd_a} !== {1'b1, 4'd2, 16'd10}) begin
               errors++; $display("FAIL fwd_add_retire: v=%0b r%0d=%0d want v=1 r2=10", rv_a, rwa_a, rwd_a);
            end
         end
         if (c == 5) begin
            checks++;
            if ({rv_b, rwa_b, rwd_b} !== {1'b1, 4'd2, 16'd10}) begin
               errors++; $display("FAIL ilk_add_retire: v=%0b r%0d=%0d want v=1 r2=10", rv_b, rwa_b, rwd_b);
            end
         end
         tick();
      end
      checks++;
      if (n_stall_a != 0) begin errors++; $display("FAIL fwd_stall_cycles: got %0d want 0", n_stall_a); end
      checks++;
      if (n_stall_b != 1) begin errors++; $display("FAIL ilk_stall_cycles: got %0d want 1", n_stall_b); end
      checks++;
      if (sc_b !== 16'd1) begin errors++; $display("FAIL ilk_stall_count: got %0d want 1", sc_b); end
   endtask

   task automatic test_branch(input bit eq);
      logic [15:0] exp_pc [4];
      logic [19:0] want;
      int n_flush = 0;
      load_nops();
      exp_q.delete();
      imem[5] = enc(4'd4, 4'd5, 4'd0, 4'd1);
      imem[6] = enc(4'd4, 4'd6, 4'd0, 4'd2);
      imem[7] = enc(4'd4, 4'd7, 4'd0, 4'd3);
      if (eq) begin
         imem[4] = enc(4'd7, 4'd1, 4'd1, 4'd3);  // BEQ r1,r1,+3
         imem[8] = enc(4'd4, 4'd8, 4'd0, 4'd4);
         exp_pc = '{16'd4, 16'd5, 16'd6, 16'd8};
         exp_q.push_back({4'd8, 16'd4});
      end else begin
         imem[0] = enc(4'd4, 4'd1, 4'd0, 4'd1);  // ADDI r1,r0,1
         imem[4] = enc(4'd7, 4'd2, 4'd1, 4'd3);  // BEQ r1,r2,+3 (1 != 0)
         exp_pc = '{16'd4, 16'd5, 16'd6, 16'd7};
         exp_q.push_back({4'd1, 16'd1});
         exp_q.push_back({4'd5, 16'd1});
         exp_q.push_back({4'd6, 16'd2});
         exp_q.push_back({4'd7, 16'd3});
      end
      do_reset();
      for (int c = 0; c < 13; c++) begin
         if (c >= 4 && c <= 7) begin
            checks++;
            if (bus_a.imem_addr !== exp_pc[c-4]) begin
               errors++; $display("FAIL br%0b_pc[c%0d]: got %0h want %0h", eq, c, bus_a.imem_addr, exp_pc[c-4]);
            end
         end
         if (flush_a) n_flush++;
         if (rv_a) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL br%0b_retire: got r%0d=%0d want none", eq, rwa_a, rwd_a);
            end else begin
               want = exp_q.pop_front();
               if ({rwa_a, rwd_a} !== want) begin
                  errors++; $display("FAIL br%0b_retire: got r%0d=%0d want r%0d=%0d", eq, rwa_a, rwd_a, want[19:16], want[15:0]);
               end
            end
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL br%0b_missing_retire: got %0d left want 0", eq, exp_q.size()); end
      checks++;
      if (n_flush != (eq ? 1 : 0)) begin errors++; $display("FAIL br%0b_flush_cycles: got %0d want %0d", eq, n_flush, eq ? 1 : 0); end
   endtask

   task automatic test_store_stall();
      int base_a, base_b;
      load_nops();
      imem[0] = enc(4'd4, 4'd3, 4'd0, 4'd7);   // ADDI r3,r0,7
      imem[3] = enc(4'd6, 4'd3, 4'd0, 4'd2);   // SW r3,2(r0)
      do_reset();
      base_a = wr_a;
      base_b = wr_b;
      for (int c = 0; c < 11; c++) begin
         ready = (c >= 5 && c <= 7) ? 1'b0 : 1'b1;
         #1;
         if (c >= 5 && c <= 7) begin
            checks++;
            if (bus_a.imem_addr !== 16'd5) begin errors++; $display("FAIL frz_pc[c%0d]: got %0h want 5", c, bus_a.imem_addr); end
            checks++;
            if ({bus_a.dmem_wen, bus_a.dmem_addr, bus_a.dmem_wdata} !== {1'b1, 16'd2, 16'd7}) begin
               errors++; $display("FAIL frz_store[c%0d]: wen=%0b addr=%0h data=%0h want 1/2/7", c, bus_a.dmem_wen, bus_a.dmem_addr, bus_a.dmem_wdata);
            end
            checks++;
            if ({stall_a, rv_a} !== 2'b10) begin errors++; $display("FAIL frz_stall[c%0d]: stall=%0b retire=%0b want 1/0", c, stall_a, rv_a); end
         end
         if (c == 8) begin
            checks++;
            if (wr_a != base_a) begin errors++; $display("FAIL early_write: got %0d writes want 0", wr_a - base_a); end
         end
         tick();
      end
      checks++;
      if (wr_a - base_a != 1) begin errors++; $display("FAIL store_count_a: got %0d want 1", wr_a - base_a); end
      checks++;
      if ({wa_addr, wa_data} !== {16'd2, 16'd7}) begin errors++; $display("FAIL store_data: got [%0h]=%0h want [2]=7", wa_addr, wa_data); end
      checks++;
      if (wr_b - base_b != 1) begin errors++; $display("FAIL store_count_b: got %0d want 1", wr_b - base_b); end
      checks++;
      if ({sc_a, sc_b} !== {16'd3, 16'd3}) begin errors++; $display("FAIL frz_stall_count: got a=%0d b=%0d want 3/3", sc_a, sc_b); end
   endtask

   task automatic test_reset_in_store();
      int base_a;
      load_nops();
      imem[0] = enc(4'd4, 4'd3, 4'd0, 4'd7);
      imem[3] = enc(4'd6, 4'd3, 4'd0, 4'd2);
      do_reset();
      base_a = wr_a;
      for (int c = 0; c < 6; c++) begin
         ready = (c == 5) ? 1'b0 : 1'b1;
         #1;
         if (c == 5) begin
            checks++;
            if (bus_a.dmem_wen !== 1'b1) begin errors++; $display("FAIL rst_store_pending: wen=%0b want 1", bus_a.dmem_wen); end
         end
         tick();
      end
      rst = 1'b0;
      ready = 1'b1;
      tick();
      checks++;
      if ({bus_a.dmem_wen, rv_a, bus_a.imem_addr} !== {1'b0, 1'b0, 16'd0}) begin
         errors++; $display("FAIL rst_store_after: wen=%0b retire=%0b pc=%0h want 0/0/0", bus_a.dmem_wen, rv_a, bus_a.imem_addr);
      end
      checks++;
      if (wr_a != base_a) begin errors++; $display("FAIL rst_store_write: got %0d writes want 0", wr_a - base_a); end
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch(1'b1);
      test_branch(1'b0);
      test_store_stall();
      test_reset_in_store();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
